layer_lut_sched: RTL and testbench

LAYER_LUT_SCHED -- requirements
Module: layer_lut_sched

---
 rtl/layer_lut_sched_if.sv | 31 +++
 rtl/layer_lut_sched.sv | 110 +++++++++++
 tb/tb_layer_lut_sched.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_lut_sched_if.sv
// Signal bundle for the shared-LUT layer scheduler: input vector stream, result stream and config port.
interface layer_lut_sched_if #(
    parameter int NUM_NEURONS = 8,
    parameter int NUM_INPUTS  = 8
);
    localparam int NW = $clog2(NUM_NEURONS);
    localparam int IW = $clog2(NUM_INPUTS);

    logic                     in_valid;
    logic                     in_ready;
    logic [2*NUM_INPUTS-1:0]  in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [2*NUM_NEURONS-1:0] out_data;
    logic                     cfg_we;
    logic                     cfg_sel;
    logic [NW+5:0]            cfg_addr;
    logic [3*IW-1:0]          cfg_data;
    logic                     cfg_err;
    logic                     busy;

    modport slave (
        input  in_valid, in_data, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_data,
        output in_ready, out_valid, out_data, cfg_err, busy
    );

    modport master (
        output in_valid, in_data, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_data,
        input  in_ready, out_valid, out_data, cfg_err, busy
    );
endinterface

// File: rtl/layer_lut_sched.sv
// Evaluates one layer of fan-in-3 LUT neurons by walking every neuron through a single
// synchronous-read LUT, one neuron per cycle, then presents the packed result vector.
module layer_lut_sched #(
    parameter int NUM_NEURONS = 8,
    parameter int NUM_INPUTS  = 8
) (
    input logic              clk,
    input logic              rst_n,
    layer_lut_sched_if.slave bus
);
    localparam int NW        = $clog2(NUM_NEURONS);
    localparam int IW        = $clog2(NUM_INPUTS);
    localparam int LUT_WORDS = NUM_NEURONS * 64;
    localparam logic [NW-1:0] LAST_N = NW'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, EVAL, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [NW-1:0]            n;
    logic [1:0]               act  [NUM_INPUTS];
    logic [IW-1:0]            conn [NUM_NEURONS][3];
    logic [1:0]               lut  [LUT_WORDS];
    logic [1:0]               lut_q;
    logic                     rd_pend;
    logic [NW-1:0]            rd_slot;
    logic                     rst_done;
    logic [2*NUM_NEURONS-1:0] out_q;
    logic                     cfg_err_q;
    logic [5:0]               rd_addr_lo;
    logic [NW+5:0]            rd_addr;
    logic                     idle;
    logic                     accept;
    logic                     cfg_ok;

    // rst_done keeps in_ready low until the first clock edge after reset is released.
    assign idle          = (state == IDLE);
    assign cfg_ok        = bus.cfg_we && idle;
    assign bus.in_ready  = rst_done && idle && !bus.cfg_we;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.busy      = !idle;
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = out_q;
    assign bus.cfg_err   = cfg_err_q;

    always_comb begin
        rd_addr_lo = '0;
        for (int k = 0; k < 3; k++)
            rd_addr_lo[2*k +: 2] = act[conn[n][k]];
    end
    assign rd_addr = {n, rd_addr_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EVAL;
            EVAL:    if (n == LAST_N) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A read issued in EVAL lands in lut_q one edge later and is stored into its slot on the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n         <= '0;
            rd_pend   <= 1'b0;
            rd_slot   <= '0;
            out_q     <= '0;
            cfg_err_q <= 1'b0;
            rst_done  <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++)
                act[i] <= '0;
            for (int j = 0; j < NUM_NEURONS; j++)
                for (int k = 0; k < 3; k++)
                    conn[j][k] <= '0;
        end else begin
            rst_done  <= 1'b1;
            cfg_err_q <= bus.cfg_we && !idle;
            rd_pend   <= (state == EVAL);
            rd_slot   <= n;
            if (accept) begin
                n <= '0;
                for (int i = 0; i < NUM_INPUTS; i++)
                    act[i] <= bus.in_data[2*i +: 2];
            end else if (state == EVAL) begin
                n <= n + 1'b1;
            end
            if (rd_pend)
                out_q[2*rd_slot +: 2] <= lut_q;
            if (cfg_ok && bus.cfg_sel)
                for (int k = 0; k < 3; k++)
                    conn[bus.cfg_addr[NW+5:6]][k] <= bus.cfg_data[IW*k +: IW];
        end
    end

    // LUT contents survive reset; software must program them before the first vector.
    always_ff @(posedge clk) begin
        if (cfg_ok && !bus.cfg_sel)
            lut[bus.cfg_addr] <= bus.cfg_data[1:0];
        lut_q <= lut[rd_addr];
    end
endmodule

// File: tb/tb_layer_lut_sched.sv
// Randomized self-checking bench for layer_lut_sched against a table-lookup reference model.
module tb_layer_lut_sched;
    localparam int NN = 8;
    localparam int NI = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   tests;
    int   failures;

    logic [1:0]  lut_m  [512];
    int          conn_m [NN][3];
    logic        inj_sel;
    logic [8:0]  inj_addr;
    logic [8:0]  inj_data;
    logic [15:0] got;

    always #5 clk = ~clk;

    layer_lut_sched_if #(.NUM_NEURONS(NN), .NUM_INPUTS(NI)) bus ();

    layer_lut_sched #(.NUM_NEURONS(NN), .NUM_INPUTS(NI)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Each neuron picks three 2-bit activations and looks up its own 64-entry table slice.
    function automatic logic [15:0] model(input logic [15:0] d);
        logic [15:0] r;
        int a [3];
        int addr;
        r = '0;
        for (int nn = 0; nn < NN; nn++) begin
            for (int k = 0; k < 3; k++)
                a[k] = int'((d >> (2 * conn_m[nn][k])) & 16'h3);
            addr = nn * 64 + a[2] * 16 + a[1] * 4 + a[0];
            r[2*nn +: 2] = lut_m[addr];
        end
        return r;
    endfunction

    task automatic modelWrite(input logic sel, input logic [8:0] addr, input logic [8:0] data);
        if (!sel)
            lut_m[addr] = data[1:0];
        else begin
            conn_m[addr[8:6]][0] = int'(data[2:0]);
            conn_m[addr[8:6]][1] = int'(data[5:3]);
            conn_m[addr[8:6]][2] = int'(data[8:6]);
        end
    endtask

    task automatic clearConn();
        for (int j = 0; j < NN; j++)
            for (int k = 0; k < 3; k++)
                conn_m[j][k] = 0;
    endtask

    task automatic cfgWrite(input logic sel, input logic [8:0] addr, input logic [8:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = sel;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        modelWrite(sel, addr, data);
    endtask

    // inject: 0 none, 1 config write in EVAL cycle 3, 2 reset in EVAL cycle 4, 3 config write alongside in_valid.
    task automatic applyStimulus(input logic [15:0] d, input int hold, input int inject, output logic [15:0] res);
        logic [15:0] exp;
        logic [15:0] snap;
        logic        accepted;
        int          c;
        int          seen;
        res      = '0;
        accepted = 1'b0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        if (inject == 3) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_sel  = inj_sel;
            bus.cfg_addr = inj_addr;
            bus.cfg_data = inj_data;
        end
        for (int w = 0; w < 20 && !accepted; w++) begin
            #3;
            if (inject == 3 && w == 0)
                checkOutput("cfg_blocks_in_ready", bus.in_ready, 0);
            accepted = bus.in_ready;
            @(posedge clk); #1;
            if (bus.cfg_we) begin
                modelWrite(bus.cfg_sel, bus.cfg_addr, bus.cfg_data);
                bus.cfg_we = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        checkOutput("accept", accepted, 1);
        if (!accepted)
            return;
        exp = model(d);
        c = 0;
        while (c < 30) begin
            c++;
            if (inject == 1 && c == 3) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_sel  = inj_sel;
                bus.cfg_addr = inj_addr;
                bus.cfg_data = inj_data;
            end
            if (inject == 2 && c == 4) begin
                rst_n = 1'b0;
                #1;
                checkOutput("abort_out_valid", bus.out_valid, 0);
                checkOutput("abort_out_data", bus.out_data, 0);
                checkOutput("abort_busy", bus.busy, 0);
                checkOutput("abort_cfg_err", bus.cfg_err, 0);
                checkOutput("abort_in_ready", bus.in_ready, 0);
                clearConn();
                @(posedge clk); #1;
                rst_n = 1'b1;
                seen = 0;
                for (int i = 0; i < 14; i++) begin
                    #3;
                    if (bus.out_valid) seen++;
                    @(posedge clk); #1;
                end
                checkOutput("abort_no_out_valid", seen, 0);
                return;
            end
            #3;
            if (c == 1)
                checkOutput("busy_in_eval", bus.busy, 1);
            if (inject == 1 && c == 4)
                checkOutput("cfg_err_pulse", bus.cfg_err, 1);
            if (inject == 1 && c == 5)
                checkOutput("cfg_err_clear", bus.cfg_err, 0);
            if (bus.out_valid)
                break;
            @(posedge clk); #1;
            bus.cfg_we = 1'b0;
        end
        checkOutput("latency", c, 10);
        if (!bus.out_valid)
            return;
        res  = bus.out_data;
        snap = bus.out_data;
        checkOutput("out_data", bus.out_data, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #4;
            checkOutput("hold_valid", bus.out_valid, 1);
            checkOutput("hold_data", bus.out_data, snap);
            checkOutput("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("ack_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        #3;
        checkOutput("idle_after_ack", bus.busy, 0);
        checkOutput("valid_dropped", bus.out_valid, 0);
        checkOutput("data_held", bus.out_data, snap);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests        = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.cfg_sel  = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        inj_sel      = 1'b0;
        inj_addr     = '0;
        inj_data     = '0;
        clearConn();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_data", bus.out_data, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_cfg_err", bus.cfg_err, 0);
        checkOutput("rst_in_ready", bus.in_ready, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("in_ready_before_edge", bus.in_ready, 0);
        @(posedge clk); #4;
        checkOutput("in_ready_after_edge", bus.in_ready, 1);
        @(posedge clk); #1;

        // Directed single-neuron case: only neuron 0 entry 010100 is non-zero.
        for (int a = 0; a < 512; a++)
            cfgWrite(1'b0, 9'(a), 9'd0);
        cfgWrite(1'b1, 9'h000, {3'd2, 3'd1, 3'd0});
        cfgWrite(1'b0, 9'h014, 9'd3);
        applyStimulus(16'h0014, 5, 0, got);
        checkOutput("directed_value", got, 16'h0003);

        inj_sel  = 1'b0;
        inj_addr = 9'h014;
        inj_data = 9'd0;
        applyStimulus(16'h0014, 0, 1, got);
        checkOutput("busy_write_result", got, 16'h0003);
        applyStimulus(16'h0014, 0, 0, got);
        checkOutput("lut_unchanged", got, 16'h0003);

        inj_sel  = 1'b0;
        inj_addr = 9'd64;
        inj_data = 9'd2;
        applyStimulus(16'h0014, 1, 3, got);
        checkOutput("cfg_then_input", got, 16'h000B);

        applyStimulus(16'h0014, 0, 2, got);
        applyStimulus(16'h0014, 0, 0, got);
        checkOutput("post_reset_vec", got, 16'h0008);
        cfgWrite(1'b1, 9'h000, {3'd2, 3'd1, 3'd0});
        applyStimulus(16'h0014, 0, 0, got);
        checkOutput("reprogram_vec", got, 16'h000B);

        // Random tables, random vectors, random back-pressure and occasional reconfiguration.
        for (int a = 0; a < 512; a++)
            cfgWrite(1'b0, 9'(a), 9'($urandom_range(0, 3)));
        for (int j = 0; j < NN; j++)
            cfgWrite(1'b1, {3'(j), 6'($urandom)}, 9'($urandom));
        for (int v = 0; v < 200; v++) begin
            if ($urandom_range(0, 4) == 0)
                cfgWrite(1'($urandom), 9'($urandom), 9'($urandom));
            applyStimulus(16'($urandom), $urandom_range(0, 4), 0, got);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
